sparse_dot_mac: RTL and testbench

Downstream consumer of the pre-sparsity shifter. It latches the 16 compacted input/weight pairs the shifter presents (non-zero pairs packed toward index 0), and multiplies and accumulates them four lanes per cycle in Qm.n fixed point. It stops early at the first all-zero group of four pairs. Accumulation can chain across several tiles, and one saturated Q(IL).(FL) dot-product result is emitted per `last` tile.

---
 rtl/sparse_dot_mac.sv | 212 +++++++++++++++++++++
 tb/tb_sparse_dot_mac.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/sparse_dot_mac.sv
// sparse_dot_mac: latches one compacted tile of 16 signed input/weight pairs,
// then multiply-accumulates four pairs per cycle. A tile ends at the first
// all-zero group of four pairs or after the fourth group. Tiles chain into
// one accumulator until a tile marked `last`. At that point the accumulator
// is scaled back to Q(IL).(FL), saturated, and held until acknowledged.
module sparse_dot_mac #(
    parameter int IL    = 4,
    parameter int FL    = 16,
    parameter int ACC_W = 48
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic signed [IL+FL-1:0] oi_0,
    input  logic signed [IL+FL-1:0] oi_1,
    input  logic signed [IL+FL-1:0] oi_2,
    input  logic signed [IL+FL-1:0] oi_3,
    input  logic signed [IL+FL-1:0] oi_4,
    input  logic signed [IL+FL-1:0] oi_5,
    input  logic signed [IL+FL-1:0] oi_6,
    input  logic signed [IL+FL-1:0] oi_7,
    input  logic signed [IL+FL-1:0] oi_8,
    input  logic signed [IL+FL-1:0] oi_9,
    input  logic signed [IL+FL-1:0] oi_10,
    input  logic signed [IL+FL-1:0] oi_11,
    input  logic signed [IL+FL-1:0] oi_12,
    input  logic signed [IL+FL-1:0] oi_13,
    input  logic signed [IL+FL-1:0] oi_14,
    input  logic signed [IL+FL-1:0] oi_15,
    input  logic signed [IL+FL-1:0] ow_0,
    input  logic signed [IL+FL-1:0] ow_1,
    input  logic signed [IL+FL-1:0] ow_2,
    input  logic signed [IL+FL-1:0] ow_3,
    input  logic signed [IL+FL-1:0] ow_4,
    input  logic signed [IL+FL-1:0] ow_5,
    input  logic signed [IL+FL-1:0] ow_6,
    input  logic signed [IL+FL-1:0] ow_7,
    input  logic signed [IL+FL-1:0] ow_8,
    input  logic signed [IL+FL-1:0] ow_9,
    input  logic signed [IL+FL-1:0] ow_10,
    input  logic signed [IL+FL-1:0] ow_11,
    input  logic signed [IL+FL-1:0] ow_12,
    input  logic signed [IL+FL-1:0] ow_13,
    input  logic signed [IL+FL-1:0] ow_14,
    input  logic signed [IL+FL-1:0] ow_15,
    input  logic                    output_ready,
    input  logic                    last,
    output logic                    input_taken,
    output logic signed [IL+FL-1:0] result,
    output logic                    result_valid,
    input  logic                    result_ack,
    output logic                    busy
);

    localparam int W  = IL + FL;
    localparam int PW = 2 * W;

    // Saturation bounds of the Q(IL).(FL) result, expressed at accumulator width.
    localparam logic signed [ACC_W-1:0] SAT_MAX = ACC_W'((64'sd1 <<< (W - 1)) - 64'sd1);
    localparam logic signed [ACC_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_COMPUTE = 2'd1,
        ST_DONE    = 2'd2
    } state_t;

    state_t                    state_q;
    logic signed [W-1:0]       oi_q [16];
    logic signed [W-1:0]       ow_q [16];
    logic                      last_q;
    logic [1:0]                g_q;
    logic signed [ACC_W-1:0]   acc_q;
    logic                      input_taken_q;
    logic                      result_valid_q;
    logic signed [W-1:0]       result_q;

    // Flat port list gathered into arrays so capture and lane muxing can loop.
    logic signed [W-1:0] oi_in [16];
    logic signed [W-1:0] ow_in [16];

    assign oi_in[0]  = oi_0;   assign ow_in[0]  = ow_0;
    assign oi_in[1]  = oi_1;   assign ow_in[1]  = ow_1;
    assign oi_in[2]  = oi_2;   assign ow_in[2]  = ow_2;
    assign oi_in[3]  = oi_3;   assign ow_in[3]  = ow_3;
    assign oi_in[4]  = oi_4;   assign ow_in[4]  = ow_4;
    assign oi_in[5]  = oi_5;   assign ow_in[5]  = ow_5;
    assign oi_in[6]  = oi_6;   assign ow_in[6]  = ow_6;
    assign oi_in[7]  = oi_7;   assign ow_in[7]  = ow_7;
    assign oi_in[8]  = oi_8;   assign ow_in[8]  = ow_8;
    assign oi_in[9]  = oi_9;   assign ow_in[9]  = ow_9;
    assign oi_in[10] = oi_10;  assign ow_in[10] = ow_10;
    assign oi_in[11] = oi_11;  assign ow_in[11] = ow_11;
    assign oi_in[12] = oi_12;  assign ow_in[12] = ow_12;
    assign oi_in[13] = oi_13;  assign ow_in[13] = ow_13;
    assign oi_in[14] = oi_14;  assign ow_in[14] = ow_14;
    assign oi_in[15] = oi_15;  assign ow_in[15] = ow_15;

    // Four MAC lanes; lane gi works on pair 4*g + gi of the latched tile.
    logic signed [PW-1:0]    prod     [4];
    logic signed [ACC_W-1:0] prod_ext [4];
    logic [3:0]              pair_nz;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : lane_g
            localparam logic [1:0] LANE = 2'(gi);
            logic [3:0]           idx;
            logic signed [W-1:0]  a_op;
            logic signed [W-1:0]  b_op;
            logic signed [PW-1:0] a_ext;
            logic signed [PW-1:0] b_ext;

            assign idx          = {g_q, LANE};
            assign a_op         = oi_q[idx];
            assign b_op         = ow_q[idx];
            assign a_ext        = {{W{a_op[W-1]}}, a_op};
            assign b_ext        = {{W{b_op[W-1]}}, b_op};
            // Full-precision product: the low PW bits of the extended multiply.
            assign prod[gi]     = a_ext * b_ext;
            assign prod_ext[gi] = {{(ACC_W - PW){prod[gi][PW-1]}}, prod[gi]};
            assign pair_nz[gi]  = (a_op != '0) && (b_op != '0);
        end
    endgenerate

    logic                    group_nz;
    logic signed [ACC_W-1:0] group_sum;
    logic signed [ACC_W-1:0] acc_d;
    logic                    exit_c;
    logic signed [ACC_W-1:0] shifted;
    logic signed [W-1:0]     sat_d;

    assign group_nz  = |pair_nz;
    assign group_sum = prod_ext[0] + prod_ext[1] + prod_ext[2] + prod_ext[3];
    assign acc_d     = group_nz ? (acc_q + group_sum) : acc_q;
    // Tile ends on an all-zero group or once the last group has been added.
    assign exit_c    = !group_nz || (g_q == 2'd3);
    // Scale back once at the end; arithmetic shift floors toward -inf.
    assign shifted   = acc_d >>> FL;

    // Clamp the scaled accumulator into the signed result range.
    always_comb begin
        sat_d = shifted[W-1:0];
        if (shifted > SAT_MAX) begin
            sat_d = SAT_MAX[W-1:0];
        end else if (shifted < SAT_MIN) begin
            sat_d = SAT_MIN[W-1:0];
        end
    end

    // Control FSM: capture in IDLE, one group per COMPUTE cycle, hold in DONE.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q        <= ST_IDLE;
            last_q         <= 1'b0;
            g_q            <= 2'd0;
            acc_q          <= '0;
            input_taken_q  <= 1'b0;
            result_valid_q <= 1'b0;
            result_q       <= '0;
            for (int i = 0; i < 16; i++) begin
                oi_q[i] <= '0;
                ow_q[i] <= '0;
            end
        end else begin
            input_taken_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (output_ready) begin
                        for (int i = 0; i < 16; i++) begin
                            oi_q[i] <= oi_in[i];
                            ow_q[i] <= ow_in[i];
                        end
                        last_q        <= last;
                        g_q           <= 2'd0;
                        input_taken_q <= 1'b1;
                        state_q       <= ST_COMPUTE;
                    end
                end
                ST_COMPUTE: begin
                    acc_q <= acc_d;
                    if (exit_c) begin
                        if (last_q) begin
                            result_q       <= sat_d;
                            result_valid_q <= 1'b1;
                            state_q        <= ST_DONE;
                        end else begin
                            // Accumulator is kept so the next tile chains onto it.
                            state_q <= ST_IDLE;
                        end
                    end else begin
                        g_q <= g_q + 2'd1;
                    end
                end
                ST_DONE: begin
                    if (result_ack) begin
                        acc_q          <= '0;
                        result_valid_q <= 1'b0;
                        state_q        <= ST_IDLE;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign input_taken  = input_taken_q;
    assign result       = result_q;
    assign result_valid = result_valid_q;
    assign busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_sparse_dot_mac.sv
// Self-checking bench for sparse_dot_mac: expected dot products are pushed to a
// scoreboard queue when a last tile is driven and compared when result_valid rises.
module tb_sparse_dot_mac;

    logic        clk;
    logic        reset;
    logic [19:0] oi_v [16];
    logic [19:0] ow_v [16];
    logic        output_ready;
    logic        last;
    logic        input_taken;
    logic [19:0] result;
    logic        result_valid;
    logic        result_ack;
    logic        busy;

    int          n_checks;
    int          n_errors;
    logic [19:0] exp_q [$];
    logic [19:0] held_result;

    sparse_dot_mac dut (
        .clk(clk), .reset(reset),
        .oi_0(oi_v[0]),   .oi_1(oi_v[1]),   .oi_2(oi_v[2]),   .oi_3(oi_v[3]),
        .oi_4(oi_v[4]),   .oi_5(oi_v[5]),   .oi_6(oi_v[6]),   .oi_7(oi_v[7]),
        .oi_8(oi_v[8]),   .oi_9(oi_v[9]),   .oi_10(oi_v[10]), .oi_11(oi_v[11]),
        .oi_12(oi_v[12]), .oi_13(oi_v[13]), .oi_14(oi_v[14]), .oi_15(oi_v[15]),
        .ow_0(ow_v[0]),   .ow_1(ow_v[1]),   .ow_2(ow_v[2]),   .ow_3(ow_v[3]),
        .ow_4(ow_v[4]),   .ow_5(ow_v[5]),   .ow_6(ow_v[6]),   .ow_7(ow_v[7]),
        .ow_8(ow_v[8]),   .ow_9(ow_v[9]),   .ow_10(ow_v[10]), .ow_11(ow_v[11]),
        .ow_12(ow_v[12]), .ow_13(ow_v[13]), .ow_14(ow_v[14]), .ow_15(ow_v[15]),
        .output_ready(output_ready), .last(last), .input_taken(input_taken),
        .result(result), .result_valid(result_valid), .result_ack(result_ack),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Clear all pairs, then load the first n pairs with a x b.
    task automatic set_ops(input int n, input logic [19:0] a, input logic [19:0] b);
        for (int i = 0; i < 16; i++) begin
            oi_v[i] = (i < n) ? a : 20'h0;
            ow_v[i] = (i < n) ? b : 20'h0;
        end
    endtask

    // After a capture edge: count COMPUTE cycles, then check the tile outcome.
    task automatic finish_tile(input string tag, input logic lst, input int exp_cycles);
        int cycles;
        cycles = 0;
        do begin
            @(posedge clk); #1;
            cycles++;
            if (cycles == 1) chk({tag, "_taken_pulse"}, input_taken, 0);
        end while (busy && !result_valid && cycles < 20);
        chk({tag, "_cycles"}, cycles, exp_cycles);
        if (lst) begin
            chk({tag, "_valid"}, result_valid, 1);
            if (exp_q.size() == 0) begin
                chk({tag, "_sb_nonempty"}, 0, 1);
            end else begin
                held_result = exp_q.pop_front();
                chk({tag, "_result"}, result, held_result);
            end
        end else begin
            chk({tag, "_no_valid"}, result_valid, 0);
            chk({tag, "_idle"}, busy, 0);
        end
        $display("tile %s: last=%0b cycles=%0d result=0x%05h valid=%0b", tag, lst, cycles, result, result_valid);
    endtask

    // Present the current operands for one edge and check the capture.
    task automatic issue(input string tag, input logic lst, input logic [19:0] exp_res, input int exp_cycles);
        @(negedge clk);
        output_ready = 1'b1;
        last         = lst;
        if (lst) exp_q.push_back(exp_res);
        @(posedge clk); #1;
        chk({tag, "_taken"}, input_taken, 1);
        chk({tag, "_busy"}, busy, 1);
        output_ready = 1'b0;
        last         = 1'b0;
        finish_tile(tag, lst, exp_cycles);
    endtask

    task automatic ack(input string tag);
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk({tag, "_ack_valid"}, result_valid, 0);
        chk({tag, "_ack_busy"}, busy, 0);
    endtask

    initial begin
        n_checks     = 0;
        n_errors     = 0;
        reset        = 1'b0;
        output_ready = 1'b0;
        last         = 1'b0;
        result_ack   = 1'b0;
        set_ops(0, 20'h0, 20'h0);

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst_taken", input_taken, 0);
        chk("rst_result", result, 0);
        chk("rst_valid", result_valid, 0);
        chk("rst_busy", busy, 0);
        @(negedge clk);
        reset = 1'b1;

        // Basic: 1.0*1.0 + 2.0*1.5 = 4.0, group 1 empty -> 2 cycles
        set_ops(1, 20'h10000, 20'h10000);
        oi_v[1] = 20'h20000; ow_v[1] = 20'h18000;
        issue("basic", 1'b1, 20'h40000, 2);
        // ack while valid=0 must be harmless later; first release this result
        ack("basic");

        // Dense saturation, positive and negative
        set_ops(16, 20'h70000, 20'h70000);
        issue("sat_pos", 1'b1, 20'h7FFFF, 4);
        ack("sat_pos");
        set_ops(16, 20'h70000, 20'h90000);
        issue("sat_neg", 1'b1, 20'h80000, 4);
        ack("sat_neg");

        // Sign and truncation toward -inf
        set_ops(1, 20'hF0000, 20'h20000);
        issue("neg_one", 1'b1, 20'hE0000, 2);
        ack("neg_one");
        set_ops(1, 20'hFFFFF, 20'h00001);
        issue("floor_lsb", 1'b1, 20'hFFFFF, 2);
        ack("floor_lsb");
        set_ops(1, 20'h00001, 20'h00001);
        issue("tiny", 1'b1, 20'h00000, 2);
        ack("tiny");

        // Early stop variants: all-zero tile, stop at group 2, zero weights stop group 1
        set_ops(0, 20'h0, 20'h0);
        issue("all_zero", 1'b1, 20'h00000, 1);
        ack("all_zero");
        set_ops(5, 20'h10000, 20'h10000);
        issue("stop_g2", 1'b1, 20'h50000, 3);
        ack("stop_g2");
        set_ops(1, 20'h10000, 20'h10000);
        for (int i = 4; i < 8; i++) oi_v[i] = 20'h10000;
        oi_v[8] = 20'h10000; ow_v[8] = 20'h10000;
        issue("w_zero_stop", 1'b1, 20'h10000, 2);
        ack("w_zero_stop");

        // Chaining: 1.0 (not last) then 0.25 (last) -> 1.25
        set_ops(1, 20'h10000, 20'h10000);
        issue("chain_a", 1'b0, 20'h0, 2);
        set_ops(1, 20'h08000, 20'h08000);
        issue("chain_b", 1'b1, 20'h14000, 2);

        // Backpressure: hold result with output_ready high, no capture
        set_ops(1, 20'h10000, 20'h10000);
        @(negedge clk);
        output_ready = 1'b1;
        last         = 1'b1;
        exp_q.push_back(20'h10000);
        for (int c = 0; c < 10; c++) begin
            @(posedge clk); #1;
            chk("bp_no_taken", input_taken, 0);
            chk("bp_stable", result, 20'h14000);
            chk("bp_valid", result_valid, 1);
        end
        // Ack edge does not capture; the following edge does
        @(negedge clk);
        result_ack = 1'b1;
        @(posedge clk); #1;
        result_ack = 1'b0;
        chk("col_ack_taken", input_taken, 0);
        chk("col_ack_valid", result_valid, 0);
        chk("col_ack_busy", busy, 0);
        @(posedge clk); #1;
        chk("col_capture", input_taken, 1);
        output_ready = 1'b0;
        last         = 1'b0;
        finish_tile("col_tile", 1'b1, 2);
        ack("col_tile");

        // Reset mid-tile at E2
        set_ops(16, 20'h70000, 20'h70000);
        @(negedge clk);
        output_ready = 1'b1;
        last         = 1'b1;
        @(posedge clk); #1;
        chk("mid_taken", input_taken, 1);
        output_ready = 1'b0;
        last         = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;
        @(posedge clk); #1;
        chk("mid_rst_taken", input_taken, 0);
        chk("mid_rst_result", result, 0);
        chk("mid_rst_valid", result_valid, 0);
        chk("mid_rst_busy", busy, 0);
        reset = 1'b1;
        set_ops(1, 20'h10000, 20'h10000);
        issue("post_rst", 1'b1, 20'h10000, 2);
        ack("post_rst");

        chk("sb_empty", exp_q.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
